// File: rtl/axil_strobe_dispatch_if.sv
// axil_strobe_dispatch_if: AXI-Lite front-end and per-target strobe/ack signals of the dispatcher
interface axil_strobe_dispatch_if #(parameter int NUM_TGT = 2);
  logic [17:0]            raddr;
  logic                   rstart;
  logic                   rready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic [17:0]            waddr;
  logic [31:0]            wdata;
  logic                   wstart;
  logic                   wready;
  logic                   bready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic [NUM_TGT-1:0]     tgt_rstr;
  logic [NUM_TGT-1:0]     tgt_wstr;
  logic [NUM_TGT-1:0]     tgt_rack;
  logic [NUM_TGT-1:0]     tgt_wack;
  logic [32*NUM_TGT-1:0]  tgt_din;
  logic [7:0]             tgt_addr;
  logic [31:0]            tgt_wdata;
  modport slave (
    input  raddr, rstart, rready, waddr, wdata, wstart, bready, tgt_rack, tgt_wack, tgt_din,
    output rdata, rresp, rvalid, wready, bresp, bvalid, tgt_rstr, tgt_wstr, tgt_addr, tgt_wdata
  );
  modport master (
    output raddr, rstart, rready, waddr, wdata, wstart, bready, tgt_rack, tgt_wack, tgt_din,
    input  rdata, rresp, rvalid, wready, bresp, bvalid, tgt_rstr, tgt_wstr, tgt_addr, tgt_wdata
  );
endinterface

// File: rtl/axil_strobe_dispatch.sv
// axil_strobe_dispatch: sequences AXI-Lite reads/writes onto per-target str/ack register banks
module axil_strobe_dispatch #(
  parameter int          NUM_TGT     = 2,
  parameter int          SEL_W       = 2,
  parameter int          TGT_SEL_LSB = 8,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input logic                   axilClk,
  input logic                   axilRst,
  axil_strobe_dispatch_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP} state_e;
  state_e             state_q, state_d;
  logic               rd_pend_q, rd_pend_d;
  logic [SEL_W-1:0]   rd_sel_q, rd_sel_d;
  logic [7:0]         rd_lo_q, rd_lo_d;
  logic               prio_q, prio_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         resp_q, resp_d;
  logic               grant_r, grant_w, g_err, rd_st, ack, expired;
  logic [SEL_W-1:0]   g_sel;
  logic [NUM_TGT-1:0] mask;
  logic [31:0]        din;
  // prio_q=1 means the write wins the next read/write collision
  assign grant_r = state_q == IDLE && rd_pend_q && !(bus.wstart && prio_q);
  assign grant_w = state_q == IDLE && bus.wstart && !grant_r;
  assign g_sel   = grant_r ? rd_sel_q : bus.waddr[TGT_SEL_LSB +: SEL_W];
  assign g_err   = 32'(g_sel) >= NUM_TGT;
  assign mask    = NUM_TGT'(1) << sel_q;
  assign rd_st   = state_q == RD_WAIT;
  assign ack     = |((rd_st ? bus.tgt_rack : bus.tgt_wack) & mask);
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    din = '0;
    for (int i = 0; i < NUM_TGT; i++) din = mask[i] ? bus.tgt_din[32*i +: 32] : din;
  end
  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    rd_sel_d  = rd_sel_q;
    rd_lo_d   = rd_lo_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    if (bus.rstart && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_sel_d  = bus.raddr[TGT_SEL_LSB +: SEL_W];
      rd_lo_d   = bus.raddr[7:0];
    end
    case (state_q)
      IDLE: if (grant_r || grant_w) begin
        state_d   = grant_r ? (g_err ? RD_RESP : RD_WAIT) : (g_err ? WR_RESP : WR_WAIT);
        rd_pend_d = grant_r ? 1'b0 : rd_pend_d;
        prio_d    = (rd_pend_q && bus.wstart) ? !prio_q : prio_q;
        sel_d     = g_sel;
        addr_d    = grant_r ? rd_lo_q : bus.waddr[7:0];
        cnt_d     = '0;
        resp_d    = g_err ? 2'b11 : 2'b00;
        wdata_d   = grant_w ? bus.wdata : wdata_q;
        rdata_d   = (grant_r && g_err) ? ERR_DATA : rdata_q;
      end
      RD_WAIT, WR_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ack || expired) begin
          state_d = rd_st ? RD_RESP : WR_RESP;
          resp_d  = ack ? 2'b00 : 2'b10;
          rdata_d = rd_st ? (ack ? din : ERR_DATA) : rdata_q;
        end
      end
      RD_RESP: state_d = bus.rready ? IDLE : state_q;
      WR_RESP: state_d = bus.bready ? IDLE : state_q;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rd_sel_q  <= '0;
      rd_lo_q   <= '0;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_sel_q  <= rd_sel_d;
      rd_lo_q   <= rd_lo_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end
  assign bus.wready    = grant_w && !axilRst;
  assign bus.rvalid    = state_q == RD_RESP;
  assign bus.bvalid    = state_q == WR_RESP;
  assign bus.rdata     = rdata_q;
  assign bus.rresp     = resp_q;
  assign bus.bresp     = resp_q;
  assign bus.tgt_rstr  = rd_st ? mask : '0;
  assign bus.tgt_wstr  = state_q == WR_WAIT ? mask : '0;
  assign bus.tgt_addr  = addr_q;
  assign bus.tgt_wdata = wdata_q;
endmodule

// File: tb/tb_axil_strobe_dispatch.sv
// tb_axil_strobe_dispatch: directed stimulus with a queue scoreboard checked by a response monitor
module tb_axil_strobe_dispatch;
  localparam int TO = 20;
  logic axilClk = 1'b0;
  logic axilRst = 1'b1;
  always #5 axilClk = ~axilClk;
  axil_strobe_dispatch_if #(.NUM_TGT(2)) bus();
  axil_strobe_dispatch #(.NUM_TGT(2), .TIMEOUT(TO)) dut (.axilClk(axilClk), .axilRst(axilRst), .bus(bus));
  int pass_cnt = 0;
  int tot_cnt = 0;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  logic [33:0] re;
  logic [1:0]  be;
  int rs_cnt[2] = '{0, 0};
  int ws_cnt[2] = '{0, 0};
  logic [31:0] ord = '0;
  int b0, b1, n;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge axilClk);
    #1;
  endtask
  // monitor: strobe accounting plus scoreboard pops on each accepted response
  always @(negedge axilClk) begin
    for (int i = 0; i < 2; i++) begin
      rs_cnt[i] += int'(bus.tgt_rstr[i]);
      ws_cnt[i] += int'(bus.tgt_wstr[i]);
    end
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("rvalid_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rdata", bus.rdata, re[33:2]);
        chk("rresp", bus.rresp, re[1:0]);
      end
      ord = {ord[27:0], 4'h1};
    end
    if (bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("bvalid_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        chk("bresp", bus.bresp, be);
      end
      ord = {ord[27:0], 4'h2};
    end
  end
  task automatic wait_str(input bit wr, input int idx);
    int k = 0;
    do begin
      @(negedge axilClk);
      k++;
    end while (!(wr ? bus.tgt_wstr[idx] : bus.tgt_rstr[idx]) && k < 60);
    chk(wr ? "wstr_seen" : "rstr_seen", wr ? bus.tgt_wstr[idx] : bus.tgt_rstr[idx], 1);
  endtask
  task automatic do_write(input logic [17:0] a, input logic [31:0] d, output int w);
    bus.waddr = a;
    bus.wdata = d;
    bus.wstart = 1'b1;
    w = 0;
    @(negedge axilClk);
    while (!bus.wready && w < 100) begin
      @(negedge axilClk);
      w++;
    end
    chk("wready_seen", bus.wready, 1);
    tick();
    bus.wstart = 1'b0;
    @(negedge axilClk);
    chk("wready_pulse", bus.wready, 0);
  endtask
  task automatic rd_pulse(input logic [17:0] a);
    bus.raddr = a;
    bus.rstart = 1'b1;
    tick();
    bus.rstart = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while ((rq.size() != 0 || bq.size() != 0) && k < 200) begin
      @(negedge axilClk);
      k++;
    end
    chk("drain", rq.size() + bq.size(), 0);
    tick();
  endtask
  initial begin
    bus.raddr = '0; bus.rstart = 0; bus.rready = 0; bus.waddr = '0; bus.wdata = '0;
    bus.wstart = 0; bus.bready = 0; bus.tgt_rack = '0; bus.tgt_wack = '0;
    bus.tgt_din = {32'h2222_2222, 32'h1111_1111};
    repeat (3) tick();
    axilRst = 1'b0;
    @(negedge axilClk);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_rstr", bus.tgt_rstr, 0);
    chk("rst_wstr", bus.tgt_wstr, 0);
    chk("rst_addr", bus.tgt_addr, 0);
    chk("rst_wdata", bus.tgt_wdata, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_bresp", bus.bresp, 0);
    tick();
    bus.rready = 1; bus.bready = 1;
    // read tgt0, ack two cycles after strobe rises
    b0 = rs_cnt[0]; b1 = rs_cnt[1];
    rq.push_back({32'h1111_1111, 2'b00});
    rd_pulse(18'h001);
    wait_str(0, 0);
    tick(); tick();
    bus.tgt_rack[0] = 1'b1;
    tick();
    bus.tgt_rack[0] = 1'b0;
    drain();
    chk("t1_rstr0_cycles", rs_cnt[0] - b0, 3);
    chk("t1_rstr1_cycles", rs_cnt[1] - b1, 0);
    // write tgt1, ack four cycles after strobe rises
    b0 = ws_cnt[0]; b1 = ws_cnt[1];
    bq.push_back(2'b00);
    do_write(18'h105, 32'hA5A5_A5A5, n);
    chk("t2_grant_wait", n, 0);
    chk("t2_tgt_addr", bus.tgt_addr, 8'h05);
    chk("t2_tgt_wdata", bus.tgt_wdata, 32'hA5A5_A5A5);
    chk("t2_wstr", bus.tgt_wstr, 2'b10);
    repeat (4) tick();
    bus.tgt_wack[1] = 1'b1;
    tick();
    bus.tgt_wack[1] = 1'b0;
    drain();
    chk("t2_wstr1_cycles", ws_cnt[1] - b1, 5);
    chk("t2_wstr0_cycles", ws_cnt[0] - b0, 0);
    // unmapped target decodes to DECERR with no strobe
    b0 = rs_cnt[0]; b1 = rs_cnt[1];
    rq.push_back({32'hDEAD_BEEF, 2'b11});
    rd_pulse(18'h234);
    drain();
    chk("t3_no_strobe", (rs_cnt[0] - b0) + (rs_cnt[1] - b1), 0);
    // silent targets time out after exactly TO strobe cycles
    b0 = rs_cnt[0];
    rq.push_back({32'hDEAD_BEEF, 2'b10});
    rd_pulse(18'h000);
    drain();
    chk("t4_rd_timeout_cycles", rs_cnt[0] - b0, TO);
    b1 = ws_cnt[1];
    bq.push_back(2'b10);
    do_write(18'h100, 32'h0000_1234, n);
    drain();
    chk("t4_wr_timeout_cycles", ws_cnt[1] - b1, TO);
    // two collisions: read wins first, write wins second
    for (int c = 0; c < 2; c++) begin
      bus.rready = 0;
      rq.push_back({32'hDEAD_BEEF, 2'b11});
      rd_pulse(18'h200);
      repeat (3) tick();
      rq.push_back({32'hDEAD_BEEF, 2'b11});
      bq.push_back(2'b11);
      bus.raddr = 18'h201;
      bus.rstart = 1'b1;
      bus.rready = 1;
      fork
        do_write(18'h300, 32'h0000_0001, n);
        begin
          tick();
          bus.rstart = 1'b0;
        end
      join
      drain();
      chk(c == 0 ? "t5_order_read_first" : "t5_order_write_first", ord[11:0], c == 0 ? 12'h112 : 12'h121);
    end
    // reset during RD_WAIT drops the transaction and the pending read
    bus.rready = 0;
    rd_pulse(18'h000);
    wait_str(0, 0);
    tick();
    bus.raddr = 18'h000;
    bus.rstart = 1'b1;
    tick();
    bus.rstart = 1'b0;
    axilRst = 1'b1;
    @(negedge axilClk);
    chk("t6_strobe_before_edge", bus.tgt_rstr[0], 1);
    tick();
    axilRst = 1'b0;
    @(negedge axilClk);
    chk("t6_rstr_after_rst", bus.tgt_rstr, 0);
    chk("t6_rvalid_after_rst", bus.rvalid, 0);
    b0 = rs_cnt[0];
    repeat (6) tick();
    chk("t6_pending_dropped", rs_cnt[0] - b0, 0);
    chk("t6_no_rvalid", bus.rvalid, 0);
    bus.rready = 1;
    // minimum read after reset: ack in the first strobe cycle
    b1 = rs_cnt[1];
    rq.push_back({32'h2222_2222, 2'b00});
    rd_pulse(18'h1FF);
    wait_str(0, 1);
    bus.tgt_rack[1] = 1'b1;
    tick();
    bus.tgt_rack[1] = 1'b0;
    @(negedge axilClk);
    chk("t6_min_read_rvalid", bus.rvalid, 1);
    drain();
    chk("t6_rstr1_cycles", rs_cnt[1] - b1, 1);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
